// File: rtl/backend_types.sv
// Shared backend types for the ROB, free list and retirement register file.
// RRF_X0_HARDWIRE_EN: when defined, architectural register 0 is hardwired to physical 0.
package backend_types;
  localparam int COMMIT_WIDTH   = 2;
  localparam int NUM_ARCH_REGS  = 32;
  localparam int NUM_PHYS_REGS  = 64;
  localparam int ARCH_REG_WIDTH = $clog2(NUM_ARCH_REGS);
  localparam int PHYS_REG_WIDTH = $clog2(NUM_PHYS_REGS);

  typedef struct packed {
    logic                      valid;
    logic [ARCH_REG_WIDTH-1:0] ard;
    logic [PHYS_REG_WIDTH-1:0] prd;
  } commit_slot_t;

  // True when a slot writes the committed map (x0 writes are dropped when hardwired).
  function automatic logic is_producer(input commit_slot_t s);
`ifdef RRF_X0_HARDWIRE_EN
    return s.valid && (s.ard != '0);
`else
    return s.valid;
`endif
  endfunction
endpackage

// File: rtl/rrf_mc_resolve.sv
// Per-slot displaced-mapping resolution with older-slot priority; purely combinational.
// RRF_X0_HARDWIRE_EN: x0 slots free their own prd when nonzero.
module rrf_mc_resolve
  import backend_types::*;
(
  input  commit_slot_t [COMMIT_WIDTH-1:0]                     slots,
  input  logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0]        arch_map,
  output logic [COMMIT_WIDTH-1:0]                             rel_valid,
  output logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]         rel_prd
);
  always_comb begin
    logic [PHYS_REG_WIDTH-1:0] old;
    rel_valid = '0;
    rel_prd   = '0;
    old       = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      old = arch_map[slots[k].ard];
      // Ascending scan: the nearest older same-ard producer overwrites earlier ones.
      for (int j = 0; j < k; j++) begin
        if (is_producer(slots[j]) && (slots[j].ard == slots[k].ard)) old = slots[j].prd;
      end
`ifdef RRF_X0_HARDWIRE_EN
      if (slots[k].ard == '0) begin
        rel_valid[k] = slots[k].valid && (slots[k].prd != '0);
        rel_prd[k]   = rel_valid[k] ? slots[k].prd : '0;
      end else if (slots[k].valid && (old != slots[k].prd)) begin
        rel_valid[k] = 1'b1;
        rel_prd[k]   = old;
      end
`else
      if (slots[k].valid && (old != slots[k].prd)) begin
        rel_valid[k] = 1'b1;
        rel_prd[k]   = old;
      end
`endif
    end
  end
endmodule

// File: rtl/rrf_mc.sv
// Multi-commit retirement register file: committed map, release register, retire counter.
// RRF_X0_HARDWIRE_EN: see backend_types; arch_map[0] then stays 0.
module rrf_mc
  import backend_types::*;
(
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [COMMIT_WIDTH-1:0]                        commit_valid,
  input  logic [COMMIT_WIDTH-1:0][ARCH_REG_WIDTH-1:0]    commit_ard,
  input  logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]    commit_prd,
  output logic                                           commit_ready,
  output logic [COMMIT_WIDTH-1:0]                        free_valid,
  output logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]    free_prd,
  input  logic                                           free_ready,
  output logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0]   arch_map,
  output logic [31:0]                                    commit_count
);
  commit_slot_t [COMMIT_WIDTH-1:0]                slots;
  logic [COMMIT_WIDTH-1:0]                        rel_valid;
  logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]    rel_prd;
  logic [31:0]                                    valid_count;
  logic                                           pending;

  always_comb begin
    valid_count = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slots[k].valid = commit_valid[k];
      slots[k].ard   = commit_ard[k];
      slots[k].prd   = commit_prd[k];
      valid_count    = valid_count + 32'(commit_valid[k]);
    end
  end

  rrf_mc_resolve u_resolve (
    .slots     (slots),
    .arch_map  (arch_map),
    .rel_valid (rel_valid),
    .rel_prd   (rel_prd)
  );

  // Handshake: the commit bundle is accepted whenever commit_ready is high; the
  // release register drains when free_ready is high. A held release freezes the
  // map and counter, and commit_ready depends only on free_valid and free_ready.
  assign pending      = |free_valid;
  assign commit_ready = !pending || free_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) arch_map[i] <= PHYS_REG_WIDTH'(i);
      free_valid   <= '0;
      free_prd     <= '0;
      commit_count <= '0;
    end else if (commit_ready) begin
      // Later (younger) slots win on the same ard.
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (is_producer(slots[k])) arch_map[slots[k].ard] <= slots[k].prd;
      end
      free_valid   <= rel_valid;
      free_prd     <= rel_prd;
      commit_count <= commit_count + valid_count;
    end
  end
endmodule

// File: tb/tb_rrf_mc.sv
// Directed plus randomized bench for rrf_mc with a reference map model and result queue.
module tb_rrf_mc;
  import backend_types::*;

  localparam int EXP_W = COMMIT_WIDTH + COMMIT_WIDTH * PHYS_REG_WIDTH + 32;

  logic                                         clk;
  logic                                         rst;
  logic [COMMIT_WIDTH-1:0]                      commit_valid;
  logic [COMMIT_WIDTH-1:0][ARCH_REG_WIDTH-1:0]  commit_ard;
  logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]  commit_prd;
  logic                                         commit_ready;
  logic [COMMIT_WIDTH-1:0]                      free_valid;
  logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]  free_prd;
  logic                                         free_ready;
  logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0] arch_map;
  logic [31:0]                                  commit_count;

  rrf_mc dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_ard   (commit_ard),
    .commit_prd   (commit_prd),
    .commit_ready (commit_ready),
    .free_valid   (free_valid),
    .free_prd     (free_prd),
    .free_ready   (free_ready),
    .arch_map     (arch_map),
    .commit_count (commit_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [PHYS_REG_WIDTH-1:0]                    m_map [NUM_ARCH_REGS];
  logic [COMMIT_WIDTH-1:0]                      m_fv;
  logic [COMMIT_WIDTH-1:0][PHYS_REG_WIDTH-1:0]  m_fp;
  logic [31:0]                                  m_cnt;
  logic [EXP_W-1:0]                             exp_q [$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0] model_map_packed();
    logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0] r;
    for (int i = 0; i < NUM_ARCH_REGS; i++) r[i] = m_map[i];
    return r;
  endfunction

  task automatic chk_map(input string tag);
    logic [NUM_ARCH_REGS-1:0][PHYS_REG_WIDTH-1:0] e;
    e = model_map_packed();
    total++;
    assert (arch_map === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, arch_map, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH_REGS; i++) m_map[i] = PHYS_REG_WIDTH'(i);
    m_fv  = '0;
    m_fp  = '0;
    m_cnt = '0;
    exp_q.delete();
  endtask

  // Apply an accepted bundle to the model and queue the resulting outputs.
  task automatic model_accept(input logic [1:0] v, input logic [4:0] a [2], input logic [5:0] p [2]);
    logic [5:0] old;
    logic       found;
    m_fv = '0;
    m_fp = '0;
    for (int k = 0; k < 2; k++) begin
      if (v[k]) begin
        old   = m_map[a[k]];
        found = 1'b0;
        for (int j = k - 1; j >= 0; j--) begin
`ifdef RRF_X0_HARDWIRE_EN
          if (!found && v[j] && a[j] == a[k] && a[j] != 0) begin old = p[j]; found = 1'b1; end
`else
          if (!found && v[j] && a[j] == a[k]) begin old = p[j]; found = 1'b1; end
`endif
        end
`ifdef RRF_X0_HARDWIRE_EN
        if (a[k] == 0) begin
          if (p[k] != 0) begin m_fv[k] = 1'b1; m_fp[k] = p[k]; end
        end else if (old != p[k]) begin m_fv[k] = 1'b1; m_fp[k] = old; end
`else
        if (old != p[k]) begin m_fv[k] = 1'b1; m_fp[k] = old; end
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
`ifdef RRF_X0_HARDWIRE_EN
      if (v[k] && a[k] != 0) m_map[a[k]] = p[k];
`else
      if (v[k]) m_map[a[k]] = p[k];
`endif
    end
    m_cnt = m_cnt + 32'(v[0]) + 32'(v[1]);
    exp_q.push_back({m_fv, m_fp, m_cnt});
  endtask

  // driver: one cycle of commit traffic, then check outputs after the edge
  task automatic step(input string tag, input logic [1:0] v, input logic [4:0] a0, input logic [5:0] p0,
                      input logic [4:0] a1, input logic [5:0] p1, input logic fr);
    logic             acc;
    logic [EXP_W-1:0] e;
    logic [4:0]       a [2];
    logic [5:0]       p [2];
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
    commit_valid = v;
    commit_ard   = {a1, a0};
    commit_prd   = {p1, p0};
    free_ready   = fr;
    #1;
    acc = !(|m_fv) || fr;
    chk({tag, ".commit_ready"}, 64'(commit_ready), 64'(acc));
    if (acc) model_accept(v, a, p);
    @(posedge clk);
    #1;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".queue_empty"}, 64'(1), 64'(0));
        e = {m_fv, m_fp, m_cnt};
      end else begin
        e = exp_q.pop_front();
      end
    end else begin
      e = {m_fv, m_fp, m_cnt};
    end
    chk({tag, ".free_valid"},   64'(free_valid),   64'(e[EXP_W-1 -: COMMIT_WIDTH]));
    chk({tag, ".free_prd"},     64'(free_prd),     64'(e[32 +: COMMIT_WIDTH*PHYS_REG_WIDTH]));
    chk({tag, ".commit_count"}, 64'(commit_count), 64'(e[31:0]));
    chk_map({tag, ".arch_map"});
  endtask

  task automatic do_reset(input string tag, input logic [1:0] v, input logic fr);
    rst          = 1'b1;
    commit_valid = v;
    commit_ard   = {5'd9, 5'd8};
    commit_prd   = {6'd61, 6'd60};
    free_ready   = fr;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk({tag, ".free_valid"},   64'(free_valid),   64'(0));
    chk({tag, ".free_prd"},     64'(free_prd),     64'(0));
    chk({tag, ".commit_count"}, 64'(commit_count), 64'(0));
    chk({tag, ".commit_ready"}, 64'(commit_ready), 64'(1));
    chk_map({tag, ".arch_map"});
  endtask

  initial begin
    rst          = 1'b1;
    commit_valid = '0;
    commit_ard   = '0;
    commit_prd   = '0;
    free_ready   = 1'b1;
    model_reset();
    @(posedge clk);
    do_reset("reset", 2'b00, 1'b1);

    // single commit displaces the reset identity mapping
    step("single", 2'b01, 5'd5, 6'd40, 5'd0, 6'd0, 1'b1);
    chk("single.map5", 64'(arch_map[5]), 64'(40));
    chk("single.fp0", 64'(free_prd[0]), 64'(5));

    // same-ard bundle: slot1 displaces slot0's prd
    step("same_ard", 2'b11, 5'd3, 6'd33, 5'd3, 6'd34, 1'b1);
    chk("same_ard.map3", 64'(arch_map[3]), 64'(34));
    chk("same_ard.fp1", 64'(free_prd[1]), 64'(33));

    // back-pressure holds everything for three cycles
    for (int i = 0; i < 3; i++) step("stall", 2'b11, 5'd10, 6'd20, 5'd11, 6'd21, 1'b0);
    step("unstall", 2'b11, 5'd10, 6'd20, 5'd11, 6'd21, 1'b1);

    step("identity", 2'b01, 5'd7, 6'd7, 5'd0, 6'd0, 1'b1);
    chk("identity.fv", 64'(free_valid), 64'(0));
    step("slot1_only", 2'b10, 5'd1, 6'd1, 5'd12, 6'd50, 1'b1);
    step("idle_drain", 2'b00, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    // younger slot re-commits the older slot's own identity prd
    step("cross_eq", 2'b11, 5'd4, 6'd44, 5'd4, 6'd4, 1'b1);

    for (int i = 0; i < 60; i++) begin
      step("rand", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
           5'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 3) != 0));
    end

    // reset with a pending release and a valid commit
    step("pre_rst", 2'b01, 5'd6, 6'd55, 5'd0, 6'd0, 1'b1);
    step("pre_rst_hold", 2'b01, 5'd2, 6'd56, 5'd0, 6'd0, 1'b0);
    do_reset("mid_reset", 2'b11, 1'b0);

`ifdef RRF_X0_HARDWIRE_EN
    step("x0_write", 2'b01, 5'd0, 6'd50, 5'd0, 6'd0, 1'b1);
    chk("x0_write.map0", 64'(arch_map[0]), 64'(0));
    chk("x0_write.fp0", 64'(free_prd[0]), 64'(50));
    step("x0_zero", 2'b01, 5'd0, 6'd0, 5'd0, 6'd0, 1'b1);
    chk("x0_zero.fv", 64'(free_valid), 64'(0));
`else
    step("x0_plain", 2'b01, 5'd0, 6'd50, 5'd0, 6'd0, 1'b1);
    chk("x0_plain.map0", 64'(arch_map[0]), 64'(50));
    chk("x0_plain.fp0", 64'(free_prd[0]), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
